// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, status bit positions and baud divisor helper for uart_core
package uart_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  localparam int ST_RX_BUSY    = 0;
  localparam int ST_TX_BUSY    = 1;
  localparam int ST_FRAME_ERR  = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_TX_EMPTY   = 4;
  localparam int ST_TX_FULL    = 5;
  localparam int ST_RX_EMPTY   = 6;
  localparam int ST_RX_FULL    = 7;

  localparam int CTRL_FLUSH_RX = 0;
  localparam int CTRL_FLUSH_TX = 1;

  function automatic int uart_div(input int clk_hz, input int baud, input int over_sample);
    return clk_hz / (baud * over_sample);
  endfunction

endpackage

// File: rtl/uart_if.sv
// rtl/uart_if.sv - CPU-side and serial-pin signal bundle of uart_core
interface uart_if #(
  parameter int DataLength = 8
);
  logic                  o_baud_clk;
  logic [1:0]            i_ctrl;
  logic [7:0]            o_status;
  logic [DataLength-1:0] i_tx_data;
  logic [DataLength-1:0] o_rx_data;
  logic                  i_tx_req;
  logic                  i_rx_req;
  logic                  o_rx_rdy;
  logic                  i_rx;
  logic                  o_tx;
  logic                  i_cts;
  logic                  o_rts;

  modport slave (
    input  i_ctrl, i_tx_data, i_tx_req, i_rx_req, i_rx, i_cts,
    output o_baud_clk, o_status, o_rx_data, o_rx_rdy, o_tx, o_rts
  );

  modport master (
    output i_ctrl, i_tx_data, i_tx_req, i_rx_req, i_rx, i_cts,
    input  o_baud_clk, o_status, o_rx_data, o_rx_rdy, o_tx, o_rts
  );
endinterface

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with show-ahead head; push to full is dropped unless popped same cycle
module uart_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [Width-1:0]       push_data,
  input  logic                   pop,
  output logic [Width-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);
  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(Depth));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - full-duplex 8N1 UART: baud tick, RX/TX FSMs, FIFOs, RTS/CTS and status word
module uart_core import uart_pkg::*; #(
  parameter int DataLength      = 8,
  parameter int FifoDepth       = 8,
  parameter int OverSample      = 8,
  parameter int BaudRate        = 115200,
  parameter int SystemClockFreq = 50_000_000
) (
  input logic  i_clk,
  input logic  i_rst,
  uart_if.slave bus
);
  localparam int DIV = uart_div(SystemClockFreq, BaudRate, OverSample);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OverSample);
  localparam int NW  = (DataLength > 1) ? $clog2(DataLength) : 1;
  localparam int CW  = $clog2(FifoDepth) + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OverSample - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OverSample / 2 - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(DataLength - 1);

  logic [BW-1:0] baud_cnt;
  logic          baud_tick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      baud_cnt  <= '0;
      baud_tick <= 1'b0;
    end else if (baud_cnt == BAUD_LAST) begin
      baud_cnt  <= '0;
      baud_tick <= 1'b1;
    end else begin
      baud_cnt  <= baud_cnt + 1'b1;
      baud_tick <= 1'b0;
    end
  end

  logic flush_rx;
  logic flush_tx;
  assign flush_rx = bus.i_ctrl[CTRL_FLUSH_RX];
  assign flush_tx = bus.i_ctrl[CTRL_FLUSH_TX];

  // ---------------- receive ----------------
  logic [1:0] rx_sync;
  logic       rx_prev;
  logic       rx_line;
  logic       rx_fall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], bus.i_rx};
      rx_prev <= rx_sync[1];
    end
  end

  assign rx_line = rx_sync[1];
  assign rx_fall = rx_prev && !rx_line;

  rx_state_t             rx_state;
  logic [TW-1:0]         rx_tick;
  logic [NW-1:0]         rx_bit;
  logic [DataLength-1:0] rx_shift;
  logic                  rx_push;
  logic                  frame_evt;

  // Tick count restarts at the start edge, so the first sample lands mid start bit
  // and every later sample lands near the centre of its bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state  <= RX_IDLE;
      rx_tick   <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_push   <= 1'b0;
      frame_evt <= 1'b0;
    end else begin
      rx_push   <= 1'b0;
      frame_evt <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_tick  <= '0;
          end
        end
        RX_START: begin
          if (baud_tick) begin
            if (rx_tick == TICK_MID) begin
              rx_tick  <= '0;
              rx_bit   <= '0;
              rx_state <= rx_line ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick <= rx_tick + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (baud_tick) begin
            if (rx_tick == TICK_LAST) begin
              rx_tick  <= '0;
              rx_shift <= {rx_line, rx_shift[DataLength-1:1]};
              if (rx_bit == BIT_LAST) rx_state <= RX_STOP;
              else                    rx_bit   <= rx_bit + 1'b1;
            end else begin
              rx_tick <= rx_tick + 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (baud_tick) begin
            if (rx_tick == TICK_LAST) begin
              rx_tick   <= '0;
              rx_state  <= RX_IDLE;
              rx_push   <= rx_line;
              frame_evt <= !rx_line;
            end else begin
              rx_tick <= rx_tick + 1'b1;
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  logic [DataLength-1:0] rx_fifo_data;
  logic                  rx_full;
  logic                  rx_empty;
  logic [CW-1:0]         rx_count;
  logic                  rx_pop;
  logic                  rx_rdy;
  logic [DataLength-1:0] rx_data;
  logic                  rx_overrun;
  logic                  frame_err;

  assign rx_pop = !rx_rdy && !rx_empty && !flush_rx;

  uart_fifo #(.Width(DataLength), .Depth(FifoDepth)) u_rx_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .flush     (flush_rx),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_pop),
    .pop_data  (rx_fifo_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_rdy     <= 1'b0;
      rx_data    <= '0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else if (flush_rx) begin
      rx_rdy     <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rx_rdy && bus.i_rx_req) begin
        rx_rdy <= 1'b0;
      end else if (rx_pop) begin
        rx_data <= rx_fifo_data;
        rx_rdy  <= 1'b1;
      end
      if (frame_evt)                       frame_err  <= 1'b1;
      if (rx_push && rx_full && !rx_pop)   rx_overrun <= 1'b1;
    end
  end

  logic [CW:0] rx_occ;
  assign rx_occ = {1'b0, rx_count} + {{CW{1'b0}}, rx_rdy};

  // ---------------- transmit ----------------
  logic [DataLength-1:0] tx_fifo_data;
  logic                  tx_full;
  logic                  tx_empty;
  logic [CW-1:0]         tx_count;
  logic                  tx_count_unused;
  logic                  tx_pop;
  tx_state_t             tx_state;
  logic [TW-1:0]         tx_tick;
  logic [NW-1:0]         tx_bit;
  logic [DataLength-1:0] tx_shift;
  logic                  tx_line;

  assign tx_count_unused = ^tx_count;

  // Frames start only on a baud tick so every bit, including the start bit, lasts exactly OverSample ticks.
  assign tx_pop = (tx_state == TX_IDLE) && baud_tick && !tx_empty && !bus.i_cts && !flush_tx;

  uart_fifo #(.Width(DataLength), .Depth(FifoDepth)) u_tx_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .flush     (flush_tx),
    .push      (bus.i_tx_req),
    .push_data (bus.i_tx_data),
    .pop       (tx_pop),
    .pop_data  (tx_fifo_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state <= TX_IDLE;
      tx_tick  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_line <= 1'b1;
          if (tx_pop) begin
            tx_shift <= tx_fifo_data;
            tx_tick  <= '0;
            tx_line  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (baud_tick) begin
            if (tx_tick == TICK_LAST) begin
              tx_tick  <= '0;
              tx_bit   <= '0;
              tx_line  <= tx_shift[0];
              tx_state <= TX_DATA;
            end else begin
              tx_tick <= tx_tick + 1'b1;
            end
          end
        end
        TX_DATA: begin
          if (baud_tick) begin
            if (tx_tick == TICK_LAST) begin
              tx_tick <= '0;
              if (tx_bit == BIT_LAST) begin
                tx_line  <= 1'b1;
                tx_state <= TX_STOP;
              end else begin
                tx_bit   <= tx_bit + 1'b1;
                tx_line  <= tx_shift[1];
                tx_shift <= tx_shift >> 1;
              end
            end else begin
              tx_tick <= tx_tick + 1'b1;
            end
          end
        end
        TX_STOP: begin
          if (baud_tick) begin
            if (tx_tick == TICK_LAST) begin
              tx_tick  <= '0;
              tx_state <= TX_IDLE;
            end else begin
              tx_tick <= tx_tick + 1'b1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  logic [7:0] status;
  always_comb begin
    status                = '0;
    status[ST_RX_FULL]    = rx_full;
    status[ST_RX_EMPTY]   = rx_empty;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_FRAME_ERR]  = frame_err;
    status[ST_TX_BUSY]    = (tx_state != TX_IDLE);
    status[ST_RX_BUSY]    = (rx_state != RX_IDLE);
  end

  assign bus.o_baud_clk = baud_tick;
  assign bus.o_status   = status;
  assign bus.o_rx_data  = rx_data;
  assign bus.o_rx_rdy   = rx_rdy;
  assign bus.o_tx       = tx_line;
  assign bus.o_rts      = (rx_occ >= (CW+1)'(FifoDepth));
endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - directed self-checking bench for uart_core
module tb_uart_core;
  localparam int RX_BIT = 434;
  localparam int TX_BIT = 432;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_if #(.DataLength(8)) bus ();

  uart_core #(
    .DataLength(8), .FifoDepth(8), .OverSample(8),
    .BaudRate(115200), .SystemClockFreq(50_000_000)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_bad    = 0;
  int rdy_at;
  int run;
  bit busy_drop;
  logic [7:0] cap;
  logic [7:0] stream_bytes [4] = '{8'h00, 8'hFF, 8'h5A, 8'h81};
  int         stream_delay [4] = '{0, 4, 10, 1};

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, output int first_rdy);
    first_rdy = -1;
    bus.i_rx = 1'b0;
    repeat (RX_BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.i_rx = b[i];
      repeat (RX_BIT) @(negedge clk);
    end
    bus.i_rx = stop_val;
    for (int i = 0; i < RX_BIT; i++) begin
      @(negedge clk);
      if (first_rdy < 0 && bus.o_rx_rdy) first_rdy = i;
    end
    bus.i_rx = 1'b1;
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!bus.o_rx_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    expect_eq({tag, "_rdy"}, 32'(bus.o_rx_rdy), 32'd1);
  endtask

  task automatic pop_rx();
    bus.i_rx_req = 1'b1;
    @(negedge clk);
    bus.i_rx_req = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    bus.i_tx_data = b;
    bus.i_tx_req  = 1'b1;
    @(negedge clk);
    bus.i_tx_req  = 1'b0;
  endtask

  task automatic wait_tx_start(input string tag);
    int n = 0;
    while (bus.o_tx && n < 120) begin
      @(negedge clk);
      n++;
    end
    expect_eq({tag, "_start"}, 32'(bus.o_tx), 32'd0);
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (bus.o_tx === lvl && n < 5000) begin
      if (!bus.o_status[1]) busy_drop = 1'b1;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.i_ctrl = 2'b00; bus.i_tx_data = 8'h00; bus.i_tx_req = 1'b0;
    bus.i_rx_req = 1'b0; bus.i_rx = 1'b1; bus.i_cts = 1'b0;

    repeat (2) @(negedge clk);
    expect_eq("rst_tx",      32'(bus.o_tx), 32'd1);
    expect_eq("rst_rdy",     32'(bus.o_rx_rdy), 32'd0);
    expect_eq("rst_status",  32'(bus.o_status), 32'h50);
    expect_eq("rst_rts",     32'(bus.o_rts), 32'd0);
    expect_eq("rst_rx_data", 32'(bus.o_rx_data), 32'd0);
    expect_eq("rst_baud",    32'(bus.o_baud_clk), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    send_frame(8'hA5, 1'b1, rdy_at);
    expect_eq("rx1_rdy_in_stop", 32'(rdy_at >= 100 && rdy_at <= 260), 32'd1);
    expect_eq("rx1_data", 32'(bus.o_rx_data), 32'hA5);
    expect_eq("rx1_idle", 32'(bus.o_status[0]), 32'd0);
    pop_rx();
    expect_eq("rx1_rdy_clr", 32'(bus.o_rx_rdy), 32'd0);
    expect_eq("rx1_hold",    32'(bus.o_rx_data), 32'hA5);
    @(negedge clk);
    expect_eq("rx1_status",  32'(bus.o_status), 32'h50);

    for (int k = 0; k < 4; k++) begin
      send_frame(stream_bytes[k], 1'b1, rdy_at);
      repeat (stream_delay[k]) @(negedge clk);
      wait_rdy("stream");
      expect_eq("stream_data", 32'(bus.o_rx_data), 32'(stream_bytes[k]));
      pop_rx();
      repeat (300) @(negedge clk);
    end

    bus.i_rx = 1'b0;
    repeat (100) @(negedge clk);
    expect_eq("glitch_busy", 32'(bus.o_status[0]), 32'd1);
    bus.i_rx = 1'b1;
    repeat (600) @(negedge clk);
    expect_eq("glitch_rdy",    32'(bus.o_rx_rdy), 32'd0);
    expect_eq("glitch_status", 32'(bus.o_status), 32'h50);

    send_frame(8'h5A, 1'b0, rdy_at);
    repeat (20) @(negedge clk);
    expect_eq("ferr_no_rdy", 32'(rdy_at < 0), 32'd1);
    expect_eq("ferr_status", 32'(bus.o_status), 32'h54);

    for (int k = 0; k < 10; k++) begin
      send_frame(8'h10 + 8'(k), 1'b1, rdy_at);
      if (k == 7) begin
        expect_eq("ovr_rts_at8",     32'(bus.o_rts), 32'd1);
        expect_eq("ovr_status_at8",  32'(bus.o_status), 32'h14);
      end
    end
    repeat (20) @(negedge clk);
    expect_eq("ovr_status", 32'(bus.o_status), 32'h9C);
    expect_eq("ovr_rts",    32'(bus.o_rts), 32'd1);
    for (int k = 0; k < 6; k++) begin
      wait_rdy("ovr");
      expect_eq("ovr_data", 32'(bus.o_rx_data), 32'h10 + 32'(k));
      pop_rx();
    end
    wait_rdy("ovr_left");
    expect_eq("ovr_left_data",   32'(bus.o_rx_data), 32'h16);
    expect_eq("ovr_left_rts",    32'(bus.o_rts), 32'd0);
    expect_eq("ovr_left_status", 32'(bus.o_status), 32'h1C);

    bus.i_ctrl = 2'b01;
    @(negedge clk);
    bus.i_ctrl = 2'b00;
    expect_eq("flush_rdy",    32'(bus.o_rx_rdy), 32'd0);
    expect_eq("flush_status", 32'(bus.o_status), 32'h50);
    repeat (5) @(negedge clk);
    expect_eq("flush_stays",  32'(bus.o_rx_rdy), 32'd0);

    busy_drop = 1'b0;
    push_tx(8'h3C);
    expect_eq("tx_queued", 32'(bus.o_status[4]), 32'd0);
    wait_tx_start("tx");
    run_len(1'b0, run);
    expect_eq("tx_low3",  32'(run), 32'd1296);
    run_len(1'b1, run);
    expect_eq("tx_high4", 32'(run), 32'd1728);
    run_len(1'b0, run);
    expect_eq("tx_low2",  32'(run), 32'd864);
    repeat (TX_BIT / 2) @(negedge clk);
    expect_eq("tx_stop",      32'(bus.o_tx), 32'd1);
    expect_eq("tx_stop_busy", 32'(bus.o_status[1]), 32'd1);
    expect_eq("tx_busy_kept", 32'(busy_drop), 32'd0);
    repeat (300) @(negedge clk);
    expect_eq("tx_done_status", 32'(bus.o_status), 32'h50);

    bus.i_cts = 1'b1;
    push_tx(8'hA7);
    busy_drop = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!bus.o_tx || bus.o_status[1]) busy_drop = 1'b1;
    end
    expect_eq("cts_held",    32'(busy_drop), 32'd0);
    expect_eq("cts_pending", 32'(bus.o_status[4]), 32'd0);
    bus.i_cts = 1'b0;
    wait_tx_start("cts");
    repeat (TX_BIT / 2) @(negedge clk);
    expect_eq("cts_start_bit", 32'(bus.o_tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (TX_BIT) @(negedge clk);
      cap[i] = bus.o_tx;
    end
    expect_eq("cts_byte", 32'(cap), 32'hA7);
    repeat (TX_BIT) @(negedge clk);
    expect_eq("cts_stop_bit", 32'(bus.o_tx), 32'd1);
    repeat (300) @(negedge clk);

    push_tx(8'h00);
    push_tx(8'h00);
    wait_tx_start("abort");
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    #1;
    expect_eq("abort_tx",     32'(bus.o_tx), 32'd1);
    expect_eq("abort_status", 32'(bus.o_status), 32'h50);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
